frame_draw_scheduler: RTL and testbench

Sequences the single VGA-adapter write port once per game frame. On each frame tick it clears the 160x120 framebuffer to the background colour, then gives exclusive port ownership to each drawing requester in turn, in fixed priority order: grid renderer, ship renderer, score/HUD renderer. It sits between the game FSM (frame tick, draw enable) and the vga_adapter write port, replacing ad-hoc muxing of renderer outputs.

---
 rtl/draw_pkg.sv | 22 ++
 rtl/clear_scanner.sv | 42 ++++
 rtl/frame_draw_scheduler.sv | 200 ++++++++++++++++++++
 tb/tb_frame_draw_scheduler.sv | 484 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/draw_pkg.sv
// rtl/draw_pkg.sv - shared drawing constants and scheduler state type
// Contents: framebuffer geometry (H_RES x V_RES), coordinate/colour widths
// shared with the renderers, background colour and the scheduler state enum.
package draw_pkg;

    localparam int X_W      = 8;
    localparam int Y_W      = 7;
    localparam int COLOUR_W = 3;
    localparam int H_RES    = 160;
    localparam int V_RES    = 120;

    localparam logic [COLOUR_W-1:0] BG_COLOUR = 3'b000;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        ARB,
        SERVE,
        DONE
    } state_t;

endpackage

// File: rtl/clear_scanner.sv
// rtl/clear_scanner.sv - raster x/y counter for full-screen clear and fill passes
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   start        reload the raster position to (0,0)
//   step         advance one pixel, x is the inner loop
//   x, y         current raster position
//   last         high while the position is the final pixel (H_RES-1, V_RES-1)
module clear_scanner #(
    parameter int H_RES = draw_pkg::H_RES,
    parameter int V_RES = draw_pkg::V_RES,
    parameter int X_W   = draw_pkg::X_W,
    parameter int Y_W   = draw_pkg::Y_W
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           step,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           last
);

    localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

    always_ff @(posedge clk) begin
        if (reset || start) begin
            x <= '0;
            y <= '0;
        end else if (step) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + Y_W'(1);
            end else begin
                x <= x + X_W'(1);
            end
        end
    end

    assign last = (x == X_LAST) && (y == Y_LAST);

endmodule

// File: rtl/frame_draw_scheduler.sv
// rtl/frame_draw_scheduler.sv - per-frame owner of the vga_adapter write port
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   frame_tick, draw_en             frame start pulse and its enable from the game FSM
//   req, req_x, req_y, req_colour   per-requester request and packed pixel slices
//   req_wr, req_done                per-requester write strobe and end-of-turn pulse
//   grant                           one-hot current port owner
//   vga_x, vga_y, vga_colour, vga_plot   vga_adapter write port
//   busy, frame_done, overrun       frame status
module frame_draw_scheduler #(
    parameter int                  N_REQ     = 3,
    parameter int                  X_W       = draw_pkg::X_W,
    parameter int                  Y_W       = draw_pkg::Y_W,
    parameter int                  COLOUR_W  = draw_pkg::COLOUR_W,
    parameter int                  H_RES     = draw_pkg::H_RES,
    parameter int                  V_RES     = draw_pkg::V_RES,
    parameter logic [COLOUR_W-1:0] BG_COLOUR = draw_pkg::BG_COLOUR,
    parameter int                  TIMEOUT   = 4096
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        frame_tick,
    input  logic                        draw_en,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ*X_W-1:0]        req_x,
    input  logic [N_REQ*Y_W-1:0]        req_y,
    input  logic [N_REQ*COLOUR_W-1:0]   req_colour,
    input  logic [N_REQ-1:0]            req_wr,
    input  logic [N_REQ-1:0]            req_done,
    output logic [N_REQ-1:0]            grant,
    output logic [X_W-1:0]              vga_x,
    output logic [Y_W-1:0]              vga_y,
    output logic [COLOUR_W-1:0]         vga_colour,
    output logic                        vga_plot,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        overrun
);

    import draw_pkg::*;

    // turn index must be able to hold N_REQ, the "all turns evaluated" value
    localparam int TURN_W = $clog2(N_REQ + 1);
    localparam int TMO_W  = $clog2(TIMEOUT);

    localparam logic [TURN_W-1:0] LAST_TURN = TURN_W'(N_REQ);
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT - 1);

    state_t               state;
    logic [TURN_W-1:0]    turn;
    logic [TMO_W-1:0]     tmo_cnt;

    // last values driven onto the port, shown whenever nobody is plotting
    logic [X_W-1:0]       hold_x;
    logic [Y_W-1:0]       hold_y;
    logic [COLOUR_W-1:0]  hold_colour;

    logic [X_W-1:0]       scan_x;
    logic [Y_W-1:0]       scan_y;
    logic                 scan_last;
    logic                 scan_start;

    logic [X_W-1:0]       sel_x;
    logic [Y_W-1:0]       sel_y;
    logic [COLOUR_W-1:0]  sel_colour;
    logic                 sel_req;
    logic                 sel_wr;
    logic                 sel_done;

    assign scan_start = (state == IDLE) && frame_tick && draw_en;

    clear_scanner #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .X_W   (X_W),
        .Y_W   (Y_W)
    ) u_scanner (
        .clk   (clk),
        .reset (reset),
        .start (scan_start),
        .step  (state == CLEAR),
        .x     (scan_x),
        .y     (scan_y),
        .last  (scan_last)
    );

    // Slice of the requester selected by the turn index; in ARB with
    // turn == N_REQ nothing matches and everything reads as zero.
    always_comb begin
        sel_x      = '0;
        sel_y      = '0;
        sel_colour = '0;
        sel_req    = 1'b0;
        sel_wr     = 1'b0;
        sel_done   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (turn == TURN_W'(i)) begin
                sel_x      = req_x[i*X_W +: X_W];
                sel_y      = req_y[i*Y_W +: Y_W];
                sel_colour = req_colour[i*COLOUR_W +: COLOUR_W];
                sel_req    = req[i];
                sel_wr     = req_wr[i];
                sel_done   = req_done[i];
            end
        end
    end

    // Clear pixels come straight from the scanner registers; renderer
    // pixels pass through with no added latency while a turn is served.
    always_comb begin
        vga_plot   = 1'b0;
        vga_x      = hold_x;
        vga_y      = hold_y;
        vga_colour = hold_colour;
        case (state)
            CLEAR: begin
                vga_plot   = 1'b1;
                vga_x      = scan_x;
                vga_y      = scan_y;
                vga_colour = BG_COLOUR;
            end
            SERVE: begin
                vga_plot   = sel_wr;
                vga_x      = sel_x;
                vga_y      = sel_y;
                vga_colour = sel_colour;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            turn        <= '0;
            tmo_cnt     <= '0;
            grant       <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
            hold_x      <= '0;
            hold_y      <= '0;
            hold_colour <= '0;
        end else begin
            frame_done <= 1'b0;
            // a tick during a frame is reported and otherwise ignored
            overrun    <= frame_tick && (state != IDLE);
            case (state)
                IDLE: begin
                    if (frame_tick && draw_en) begin
                        state <= CLEAR;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    hold_x      <= scan_x;
                    hold_y      <= scan_y;
                    hold_colour <= BG_COLOUR;
                    if (scan_last) begin
                        state <= ARB;
                        turn  <= '0;
                    end
                end
                ARB: begin
                    if (turn == LAST_TURN) begin
                        state      <= DONE;
                        frame_done <= 1'b1;
                    end else if (sel_req) begin
                        grant   <= N_REQ'(1) << turn;
                        tmo_cnt <= '0;
                        state   <= SERVE;
                    end else begin
                        turn <= turn + TURN_W'(1);
                    end
                end
                SERVE: begin
                    hold_x      <= sel_x;
                    hold_y      <= sel_y;
                    hold_colour <= sel_colour;
                    tmo_cnt     <= tmo_cnt + TMO_W'(1);
                    if (sel_done || (tmo_cnt == TMO_LAST)) begin
                        grant <= '0;
                        turn  <= turn + TURN_W'(1);
                        state <= ARB;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// tb/tb_frame_draw_scheduler.sv - randomized self-checking bench for frame_draw_scheduler
module tb_frame_draw_scheduler;

    localparam int N_REQ     = 3;
    localparam int X_W       = 8;
    localparam int Y_W       = 7;
    localparam int CW        = 3;
    localparam int H         = 160;
    localparam int V         = 120;
    localparam int TMO       = 16;
    localparam int CLEAR_PIX = H * V;
    localparam int BASE_LAT  = CLEAR_PIX + 5;
    localparam int BUDGET    = CLEAR_PIX + 400;

    logic                  clk = 1'b0;
    logic                  reset, frame_tick, draw_en;
    logic [N_REQ-1:0]      req, req_wr, req_done;
    logic [N_REQ*X_W-1:0]  req_x;
    logic [N_REQ*Y_W-1:0]  req_y;
    logic [N_REQ*CW-1:0]   req_colour;
    logic [N_REQ-1:0]      grant;
    logic [X_W-1:0]        vga_x;
    logic [Y_W-1:0]        vga_y;
    logic [CW-1:0]         vga_colour;
    logic                  vga_plot, busy, frame_done, overrun;

    int n_cmp  = 0;
    int n_fail = 0;

    always #10 clk = ~clk;

    frame_draw_scheduler #(
        .N_REQ    (N_REQ),
        .X_W      (X_W),
        .Y_W      (Y_W),
        .COLOUR_W (CW),
        .H_RES    (H),
        .V_RES    (V),
        .BG_COLOUR(3'b000),
        .TIMEOUT  (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .frame_tick (frame_tick),
        .draw_en    (draw_en),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_colour (req_colour),
        .req_wr     (req_wr),
        .req_done   (req_done),
        .grant      (grant),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot),
        .busy       (busy),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    typedef struct packed {
        logic           wr;
        logic           done;
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [CW-1:0]  c;
    } act_t;

    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [CW-1:0]  c;
    } pix_t;

    // requester behaviour scripts, one action per granted cycle
    act_t             script[N_REQ][$];
    int               turn_len_exp[N_REQ];
    bit               garbage;

    // model of the frame: expected renderer pixels in port order
    pix_t             exp_q[$];
    pix_t             cap_q[$];

    int               first_plot, last_plot, done_cnt, done_cyc, ovr_cnt, ovr_cyc, bad_grant;
    int               grant_len[N_REQ];
    logic             busy_at_done, busy_after_done;
    logic [N_REQ-1:0] grant_order[$];

    task automatic build_script(input int i, input int npix, input bit hang_i);
        act_t a;
        bit   done_set;
        script[i].delete();
        done_set = 1'b0;
        for (int k = 0; k < npix; k++) begin
            if ($urandom_range(0, 2) == 0) begin
                a = '0;
                script[i].push_back(a);
            end
            a.wr   = 1'b1;
            a.x    = X_W'($urandom_range(0, H - 1));
            a.y    = Y_W'($urandom_range(0, V - 1));
            a.c    = CW'($urandom);
            a.done = !hang_i && (k == npix - 1) && ($urandom_range(0, 1) == 1);
            if (a.done) done_set = 1'b1;
            script[i].push_back(a);
        end
        if (!hang_i && !done_set) begin
            a = '0;
            a.done = 1'b1;
            script[i].push_back(a);
        end
        turn_len_exp[i] = hang_i ? TMO : script[i].size();
    endtask

    task automatic build_expected(input logic [N_REQ-1:0] r);
        pix_t p;
        exp_q.delete();
        for (int i = 0; i < N_REQ; i++) begin
            if (r[i]) begin
                foreach (script[i][k]) begin
                    if (script[i][k].wr) begin
                        p.x = script[i][k].x;
                        p.y = script[i][k].y;
                        p.c = script[i][k].c;
                        exp_q.push_back(p);
                    end
                end
            end
        end
    endtask

    task automatic count_pixel_errors(output int clear_bad, output int req_bad);
        pix_t e;
        clear_bad = 0;
        req_bad   = 0;
        for (int k = 0; k < CLEAR_PIX; k++) begin
            e.x = X_W'(k % H);
            e.y = Y_W'(k / H);
            e.c = '0;
            if (k >= cap_q.size()) clear_bad++;
            else if (cap_q[k] !== e) clear_bad++;
        end
        foreach (exp_q[j]) begin
            if (CLEAR_PIX + j >= cap_q.size()) req_bad++;
            else if (cap_q[CLEAR_PIX + j] !== exp_q[j]) req_bad++;
        end
    endtask

    // Runs one frame from a tick issued in the current cycle; optionally a
    // second tick at cycle tick2. Called and returns at posedge+1.
    task automatic run_frame(input logic [N_REQ-1:0] r, input int tick2);
        int               c;
        int               pos[N_REQ];
        act_t             a;
        logic [N_REQ-1:0] g_prev;
        logic [N_REQ-1:0] one_i;
        cap_q.delete();
        grant_order.delete();
        first_plot = -1; last_plot = -1; done_cnt = 0; done_cyc = -1;
        ovr_cnt = 0; ovr_cyc = -1; bad_grant = 0;
        busy_at_done = 1'bx; busy_after_done = 1'bx;
        for (int i = 0; i < N_REQ; i++) begin
            pos[i] = 0;
            grant_len[i] = 0;
        end
        g_prev = '0;
        req = r; draw_en = 1'b1; frame_tick = 1'b1;
        c = 0;
        while (c < BUDGET && !(done_cnt > 0 && c >= done_cyc + 20)) begin
            if (c > 0) frame_tick = (c == tick2);
            req_wr = '0;
            req_done = '0;
            for (int i = 0; i < N_REQ; i++) begin
                one_i = N_REQ'(1) << i;
                if (grant == one_i) begin
                    if (pos[i] < script[i].size()) begin
                        a = script[i][pos[i]];
                        pos[i]++;
                        req_wr[i]   = a.wr;
                        req_done[i] = a.done;
                        req_x[i*X_W +: X_W]    = a.x;
                        req_y[i*Y_W +: Y_W]    = a.y;
                        req_colour[i*CW +: CW] = a.c;
                    end
                end else if (garbage) begin
                    req_wr[i]   = 1'($urandom_range(0, 1));
                    req_done[i] = 1'($urandom_range(0, 1));
                    req_x[i*X_W +: X_W]    = X_W'($urandom);
                    req_y[i*Y_W +: Y_W]    = Y_W'($urandom);
                    req_colour[i*CW +: CW] = CW'($urandom);
                end
            end
            @(negedge clk);
            if (vga_plot) begin
                cap_q.push_back({vga_x, vga_y, vga_colour});
                if (first_plot < 0) first_plot = c;
                last_plot = c;
            end
            if (frame_done) begin
                done_cnt++;
                if (done_cnt == 1) begin
                    done_cyc = c;
                    busy_at_done = busy;
                end
            end
            if (done_cnt > 0 && c == done_cyc + 1) busy_after_done = busy;
            if (overrun) begin
                ovr_cnt++;
                ovr_cyc = c;
            end
            if (grant != '0) begin
                if (!$onehot(grant)) bad_grant++;
                if (grant != g_prev) grant_order.push_back(grant);
                for (int i = 0; i < N_REQ; i++) if (grant[i]) grant_len[i]++;
            end
            g_prev = grant;
            @(posedge clk); #1;
            c++;
        end
        frame_tick = 1'b0; req = '0; req_wr = '0; req_done = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        n_cmp++;
        if ({grant, vga_plot, busy, frame_done, overrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got grant=%b plot=%b busy=%b done=%b ovr=%b required all 0",
                     grant, vga_plot, busy, frame_done, overrun);
        end
        n_cmp++;
        if ({vga_x, vga_y, vga_colour} !== '0) begin
            n_fail++;
            $display("FAIL reset_coords: got x=%0d y=%0d c=%0d required 0 0 0", vga_x, vga_y, vga_colour);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({grant, vga_plot, busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_release: got grant=%b plot=%b busy=%b required 0", grant, vga_plot, busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_draw_disabled();
        int busy_cnt, plot_cnt, ovr_n, done_n;
        busy_cnt = 0; plot_cnt = 0; ovr_n = 0; done_n = 0;
        draw_en = 1'b0;
        frame_tick = 1'b1;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) frame_tick = 1'b0;
            @(negedge clk);
            busy_cnt += int'(busy);
            plot_cnt += int'(vga_plot);
            ovr_n    += int'(overrun);
            done_n   += int'(frame_done);
            @(posedge clk); #1;
        end
        n_cmp++;
        if (busy_cnt !== 0 || plot_cnt !== 0) begin
            n_fail++;
            $display("FAIL disabled_idle: busy cycles %0d plots %0d required 0 0", busy_cnt, plot_cnt);
        end
        n_cmp++;
        if (ovr_n !== 0 || done_n !== 0) begin
            n_fail++;
            $display("FAIL disabled_flags: overrun %0d frame_done %0d required 0 0", ovr_n, done_n);
        end
    endtask

    task automatic test_clear_overrun();
        int clear_bad, req_bad;
        garbage = 1'b0;
        for (int i = 0; i < N_REQ; i++) script[i].delete();
        build_expected(3'b000);
        // second tick lands on the cycle clear pixel (50,10) is on the port
        run_frame(3'b000, 1 + 10 * H + 50);
        count_pixel_errors(clear_bad, req_bad);
        n_cmp++;
        if (cap_q.size() !== CLEAR_PIX) begin
            n_fail++;
            $display("FAIL clear_count: got %0d plots required %0d", cap_q.size(), CLEAR_PIX);
        end
        n_cmp++;
        if (clear_bad !== 0) begin
            n_fail++;
            $display("FAIL clear_raster: %0d bad clear pixels required 0", clear_bad);
        end
        n_cmp++;
        if (first_plot !== 1 || last_plot !== CLEAR_PIX) begin
            n_fail++;
            $display("FAIL clear_span: got first %0d last %0d required 1 %0d", first_plot, last_plot, CLEAR_PIX);
        end
        n_cmp++;
        if (done_cnt !== 1 || done_cyc !== BASE_LAT) begin
            n_fail++;
            $display("FAIL clear_done: got count %0d at %0d required 1 at %0d", done_cnt, done_cyc, BASE_LAT);
        end
        n_cmp++;
        if (busy_at_done !== 1'b1 || busy_after_done !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_busy: got %b then %b required 1 then 0", busy_at_done, busy_after_done);
        end
        n_cmp++;
        if (ovr_cnt !== 1 || ovr_cyc !== 2 + 10 * H + 50) begin
            n_fail++;
            $display("FAIL overrun_pulse: got count %0d at %0d required 1 at %0d", ovr_cnt, ovr_cyc, 2 + 10 * H + 50);
        end
        n_cmp++;
        if (grant_order.size() !== 0) begin
            n_fail++;
            $display("FAIL clear_no_grant: got %0d grants required 0", grant_order.size());
        end
    endtask

    task automatic test_priority_serve();
        int clear_bad, req_bad;
        garbage = 1'b1;
        build_script(0, 4, 1'b0);
        build_script(1, 2, 1'b0);
        script[2].delete();
        build_expected(3'b011);
        run_frame(3'b011, -1);
        garbage = 1'b0;
        count_pixel_errors(clear_bad, req_bad);
        n_cmp++;
        if (cap_q.size() !== CLEAR_PIX + exp_q.size()) begin
            n_fail++;
            $display("FAIL serve_count: got %0d plots required %0d", cap_q.size(), CLEAR_PIX + exp_q.size());
        end
        n_cmp++;
        if (req_bad !== 0 || clear_bad !== 0) begin
            n_fail++;
            $display("FAIL serve_pixels: got %0d bad owner pixels, %0d bad clear pixels required 0 0", req_bad, clear_bad);
        end
        n_cmp++;
        if (grant_order.size() !== 2 || grant_order[0] !== 3'b001 || grant_order[1] !== 3'b010 || bad_grant !== 0) begin
            n_fail++;
            $display("FAIL serve_order: got %0d grants first %b second %b bad %0d required 001 then 010",
                     grant_order.size(), grant_order[0], grant_order[1], bad_grant);
        end
        n_cmp++;
        if (grant_len[0] !== turn_len_exp[0] || grant_len[1] !== turn_len_exp[1] || grant_len[2] !== 0) begin
            n_fail++;
            $display("FAIL serve_turns: got %0d %0d %0d required %0d %0d 0",
                     grant_len[0], grant_len[1], grant_len[2], turn_len_exp[0], turn_len_exp[1]);
        end
        n_cmp++;
        if (done_cnt !== 1 || done_cyc !== BASE_LAT + turn_len_exp[0] + turn_len_exp[1]) begin
            n_fail++;
            $display("FAIL serve_done: got count %0d at %0d required 1 at %0d",
                     done_cnt, done_cyc, BASE_LAT + turn_len_exp[0] + turn_len_exp[1]);
        end
    endtask

    task automatic test_timeout();
        int clear_bad, req_bad;
        garbage = 1'b0;
        script[0].delete();
        build_script(1, 3, 1'b1);
        build_script(2, $urandom_range(1, 5), 1'b0);
        build_expected(3'b110);
        run_frame(3'b110, -1);
        count_pixel_errors(clear_bad, req_bad);
        n_cmp++;
        if (grant_len[1] !== TMO) begin
            n_fail++;
            $display("FAIL timeout_len: got %0d grant cycles required %0d", grant_len[1], TMO);
        end
        n_cmp++;
        if (grant_order.size() !== 2 || grant_order[0] !== 3'b010 || grant_order[1] !== 3'b100) begin
            n_fail++;
            $display("FAIL timeout_order: got %0d grants first %b second %b required 010 then 100",
                     grant_order.size(), grant_order[0], grant_order[1]);
        end
        n_cmp++;
        if (req_bad !== 0 || cap_q.size() !== CLEAR_PIX + exp_q.size()) begin
            n_fail++;
            $display("FAIL timeout_pixels: got %0d bad, %0d plots required 0, %0d",
                     req_bad, cap_q.size(), CLEAR_PIX + exp_q.size());
        end
        n_cmp++;
        if (done_cnt !== 1 || done_cyc !== BASE_LAT + TMO + turn_len_exp[2]) begin
            n_fail++;
            $display("FAIL timeout_done: got count %0d at %0d required 1 at %0d",
                     done_cnt, done_cyc, BASE_LAT + TMO + turn_len_exp[2]);
        end
    endtask

    task automatic test_reset_mid_serve();
        int  c, done_n, plot_n;
        bit  found;
        draw_en = 1'b1;
        req = 3'b001;
        frame_tick = 1'b1;
        found = 1'b0;
        c = 0;
        while (c < BUDGET && !found) begin
            @(negedge clk);
            if (grant == 3'b001) found = 1'b1;
            @(posedge clk); #1;
            frame_tick = 1'b0;
            c++;
        end
        n_cmp++;
        if (!found) begin
            n_fail++;
            $display("FAIL midreset_grant: grant 001 not seen within %0d cycles", BUDGET);
        end
        req_wr = 3'b001;
        req_x[X_W-1:0] = X_W'($urandom_range(0, H - 1));
        req_y[Y_W-1:0] = Y_W'($urandom_range(0, V - 1));
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (grant !== 3'b000 || vga_plot !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_state: got grant=%b plot=%b busy=%b required 000 0 0", grant, vga_plot, busy);
        end
        done_n = 0;
        plot_n = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            @(negedge clk);
            done_n += int'(frame_done);
            plot_n += int'(vga_plot);
        end
        n_cmp++;
        if (done_n !== 0 || plot_n !== 0) begin
            n_fail++;
            $display("FAIL midreset_quiet: got %0d frame_done %0d plots required 0 0", done_n, plot_n);
        end
        @(posedge clk); #1;
        req_wr = '0;
        req = '0;
        frame_tick = 1'b1;
        @(posedge clk); #1;
        frame_tick = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (vga_plot !== 1'b1 || vga_x !== 8'd0 || vga_y !== 7'd0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL restart_origin: got plot=%b (%0d,%0d) busy=%b required 1 (0,0) 1",
                     vga_plot, vga_x, vga_y, busy);
        end
        @(posedge clk); #1;
        @(negedge clk);
        n_cmp++;
        if (vga_x !== 8'd1 || vga_y !== 7'd0) begin
            n_fail++;
            $display("FAIL restart_step: got (%0d,%0d) required (1,0)", vga_x, vga_y);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; frame_tick = 1'b0; draw_en = 1'b0;
        req = '0; req_wr = '0; req_done = '0;
        req_x = '0; req_y = '0; req_colour = '0;
        garbage = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_draw_disabled();
        test_clear_overrun();
        test_priority_serve();
        test_timeout();
        test_reset_mid_serve();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
